// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the requester, FIFO write and status signals of fifo_wr_arbiter.
//   The master side drives the requests, the packed data and the full flag.
//   The slave side is the arbiter itself.
//
//   req      requester -> arbiter   per-requester "word available" level
//   req_data requester -> arbiter   packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full     FIFO -> arbiter        FIFO full flag
//   gnt      arbiter -> requester   one-hot current owner, zero when idle
//   ack      arbiter -> requester   one-cycle pulse on owner bit per written word
//   w_inc    arbiter -> FIFO        write increment
//   wr_data  arbiter -> FIFO        write data
//   busy     arbiter -> status      high while a burst is in progress
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_inc;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          busy;

  modport master (
    output req, req_data, full,
    input  gnt, ack, w_inc, wr_data, busy
  );

  modport slave (
    input  req, req_data, full,
    output gnt, ack, w_inc, wr_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets one of NUM_REQ requesters write a burst of
//   up to BURST_LEN words into a FIFO. Arbitration only happens in IDLE, and
//   every grant is followed by exactly one IDLE cycle.
//
//   state | meaning
//   IDLE  | no owner; pick the next requester after last_owner
//   BURST | owner writes a word each cycle it has data and the FIFO is not full
//
//   i_clk   clock, write-side domain of the FIFO
//   i_rst   synchronous active-high reset
//   io_bus  slave modport of fifo_wr_arbiter_if (requests, FIFO write, status)
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fifo_wr_arbiter_if.slave io_bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int PW = OW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]            r_state;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         r_last_owner;
  logic [BW-1:0]         r_beat_cnt;

  logic                  w_busy;
  logic                  w_owner_req;
  logic                  w_inc;
  logic                  w_last_beat;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic [2*NUM_REQ-1:0]  w_req_dbl;
  logic [NUM_REQ-1:0]    w_req_rot;
  logic [PW-1:0]         w_base;
  logic [PW-1:0]         w_sum;
  logic [OW-1:0]         w_pick;

  assign w_busy = (r_state == ST_BURST);

  // Owner decode: one-hot grant, owner's request level and owner's data slice.
  always_comb begin
    w_gnt        = '0;
    w_owner_req  = 1'b0;
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_gnt[i]     = w_busy;
        w_owner_req  = io_bus.req[i];
        w_owner_data = io_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Rotate the request vector so bit 0 is the requester after last_owner,
  // then take the lowest set bit. Scanning downward lets the last hit win,
  // which is the lowest offset. w_base can reach NUM_REQ, hence the wrap.
  assign w_req_dbl = {io_bus.req, io_bus.req};
  assign w_base    = {1'b0, r_last_owner} + PW'(1);

  always_comb begin
    w_req_rot = w_req_dbl[w_base +: NUM_REQ];
    w_sum     = w_base;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) w_sum = w_base + PW'(j);
    end
    w_pick = (w_sum >= PW'(NUM_REQ)) ? OW'(w_sum - PW'(NUM_REQ)) : OW'(w_sum);
  end

  // Reset gates the write combinationally so a burst killed mid-way never
  // pushes a word in the reset cycle.
  assign w_inc       = w_busy & w_owner_req & ~io_bus.full & ~i_rst;
  assign w_last_beat = (r_beat_cnt == BW'(BURST_LEN - 1));

  assign io_bus.gnt     = w_gnt;
  assign io_bus.ack     = w_gnt & {NUM_REQ{w_inc}};
  assign io_bus.w_inc   = w_inc;
  assign io_bus.wr_data = w_busy ? w_owner_data : '0;
  assign io_bus.busy    = w_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_beat_cnt   <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|io_bus.req) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_inc) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            if (w_last_beat) begin
              r_state      <= ST_IDLE;
              r_last_owner <= r_owner;
            end
          end else if (!w_owner_req) begin
            r_state      <= ST_IDLE;
            r_last_owner <= r_owner;
          end
          // FIFO full with data pending: hold everything until full falls.
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
